// File: rtl/mem_arbiter.sv
// Arbitrates the single pmem line port between icache and dcache.
// Data cache wins by default; a starve counter forces an icache grant after STARVE_LIMIT D wins.
module mem_arbiter #(
    parameter int LINE_BITS    = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_read,
    input  logic [31:0]          i_addr,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_resp,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [31:0]          d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);
    // state   | meaning
    // IDLE    | sample requests, pick a winner and latch its transaction
    // SERVE_I | icache line read in flight on pmem
    // SERVE_D | dcache read or writeback in flight on pmem
    // RESP    | one-cycle completion pulse to the granted requester

    localparam int          OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int          CNT_BITS    = $clog2(STARVE_LIMIT + 1);
    localparam logic [31:0] ADDR_MASK   = ~((32'd1 << OFFSET_BITS) - 32'd1);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;
    typedef enum logic [1:0] {GRANT_NONE, GRANT_I, GRANT_D} grant_t;

    state_t               state;
    state_t               state_next;
    grant_t               grant;
    logic [31:0]          addr_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic [LINE_BITS-1:0] line_buf;
    logic                 write_q;
    logic [CNT_BITS-1:0]  starve_cnt;
    logic                 d_req;
    logic                 starve_hit;
    logic                 serving;

    assign d_req      = d_read | d_write;
    assign starve_hit = (starve_cnt == CNT_BITS'(STARVE_LIMIT));
    assign serving    = (state == SERVE_I) || (state == SERVE_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_req && !(i_read && starve_hit)) begin
                    state_next = SERVE_D;
                end else if (i_read) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction latch, returned-line buffer and starvation bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= GRANT_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            line_buf   <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_next == SERVE_D) begin
                        grant   <= GRANT_D;
                        addr_q  <= d_addr & ADDR_MASK;
                        wdata_q <= d_wdata;
                        write_q <= d_write;
                        if (i_read && !starve_hit) begin
                            starve_cnt <= starve_cnt + CNT_BITS'(1);
                        end
                    end else if (state_next == SERVE_I) begin
                        grant      <= GRANT_I;
                        addr_q     <= i_addr & ADDR_MASK;
                        wdata_q    <= d_wdata;
                        write_q    <= 1'b0;
                        starve_cnt <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        line_buf <= pmem_rdata;
                    end
                end
                RESP:    grant <= GRANT_NONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        if (serving) begin
            pmem_read  = !write_q;
            pmem_write = write_q;
        end
        if (state == RESP) begin
            i_resp = (grant == GRANT_I);
            d_resp = (grant == GRANT_D);
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_rdata      = line_buf;
    assign d_rdata      = line_buf;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_mem_arbiter;
    localparam int LB         = 256;
    localparam int LIMIT      = 4;
    localparam int LINE_BYTES = LB / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0;
    logic [31:0]   i_addr = '0;
    logic [LB-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [LB-1:0] d_wdata = '0;
    logic [LB-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [LB-1:0] pmem_wdata;
    logic [LB-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    mem_arbiter #(.LINE_BITS(LB), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] v;
        v = '0;
        for (int w = 0; w < LB / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: phase 0 waiting, 1 memory busy, 2 responding; owner 1=I, 2=D
    int            m_phase = 0;
    int            m_owner = 0;
    int            m_starve = 0;
    int            pick;
    logic [31:0]   m_addr = '0;
    logic          m_wr = 1'b0;
    logic [LB-1:0] m_wdata = '0;
    logic [LB-1:0] m_line = '0;
    bit            chk_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  = 0;
            m_owner  = 0;
            m_starve = 0;
            m_line   = '0;
        end else if (m_phase == 0) begin
            pick = 0;
            if ((d_read || d_write) && i_read) pick = (m_starve == LIMIT) ? 1 : 2;
            else if (d_read || d_write)        pick = 2;
            else if (i_read)                   pick = 1;
            if (pick == 2) begin
                m_addr  = (d_addr / LINE_BYTES) * LINE_BYTES;
                m_wr    = d_write;
                m_wdata = d_wdata;
                if (i_read) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            end else if (pick == 1) begin
                m_addr   = (i_addr / LINE_BYTES) * LINE_BYTES;
                m_wr     = 1'b0;
                m_starve = 0;
            end
            if (pick != 0) begin
                m_owner = pick;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (pmem_resp) begin
                m_line  = pmem_rdata;
                m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pmem_read", pmem_read, m_phase == 1 && !m_wr);
            chk("pmem_write", pmem_write, m_phase == 1 && m_wr);
            chk("pmem_rw_exclusive", pmem_read && pmem_write, 1'b0);
            if (m_phase == 1) chk("pmem_address", pmem_address, m_addr);
            if (m_phase == 1 && m_wr) chk("pmem_wdata", pmem_wdata, m_wdata);
            chk("i_resp", i_resp, m_phase == 2 && m_owner == 1);
            chk("d_resp", d_resp, m_phase == 2 && m_owner == 2);
            if (m_phase == 2 && m_owner == 1) chk("i_rdata", i_rdata, m_line);
            if (m_phase == 2 && m_owner == 2 && !m_wr) chk("d_rdata", d_rdata, m_line);
            chk_int("starve_cnt", int'(dut.starve_cnt), m_starve);
        end
    end

    always @(posedge clk) begin
        assert (!(d_read && d_write)) else $error("bench drove d_read and d_write together");
    end

    // Memory model and requester agents, stepped once per cycle 2 time units after the edge
    int            mem_lat = 0;
    bit            mem_busy = 1'b0;
    int            mem_cnt = 0;
    bit            rand_on = 1'b0;
    bit            spurious = 1'b0;
    bit            in_service = 1'b0;
    logic [LB-1:0] last_rdata = '0;
    int            n_iresp = 0;
    int            n_dresp = 0;
    int            svc_log[$];
    int            starve_log[$];
    logic [31:0]   addr_log[$];

    task automatic step();
        @(posedge clk);
        #2;
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        if (rst) begin
            mem_busy = 1'b0;
        end else if (pmem_read || pmem_write) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 4)) : mem_lat;
            end
            if (mem_cnt == 0) begin
                pmem_resp  = 1'b1;
                mem_busy   = 1'b0;
                last_rdata = pmem_rdata;
            end else begin
                mem_cnt--;
            end
        end else if (spurious && $urandom_range(0, 9) == 0) begin
            pmem_resp = 1'b1;
        end
        if ((pmem_read || pmem_write) && !in_service) begin
            svc_log.push_back((pmem_address[31:28] == 4'h0) ? 1 : 2);
            starve_log.push_back(int'(dut.starve_cnt));
            addr_log.push_back(pmem_address);
        end
        in_service = pmem_read || pmem_write;
        if (i_resp) begin
            i_read = 1'b0;
            n_iresp++;
        end
        if (d_resp) begin
            d_read  = 1'b0;
            d_write = 1'b0;
            n_dresp++;
        end
        if (rand_on) begin
            if (rst) begin
                rst = 1'b0;
            end else begin
                if (!i_read && !i_resp && $urandom_range(0, 99) < 40) begin
                    i_read = 1'b1;
                    i_addr = $urandom;
                end else if (i_read && $urandom_range(0, 4) == 0) begin
                    i_addr = $urandom;
                end
                if (!(d_read || d_write) && !d_resp && $urandom_range(0, 99) < 40) begin
                    if ($urandom_range(0, 99) < 30) d_write = 1'b1;
                    else                            d_read  = 1'b1;
                    d_addr  = $urandom;
                    d_wdata = rand_line();
                end else if ((d_read || d_write) && $urandom_range(0, 4) == 0) begin
                    d_addr  = $urandom;
                    d_wdata = rand_line();
                end
                if ($urandom_range(0, 299) == 0) begin
                    rst     = 1'b1;
                    i_read  = 1'b0;
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pmem_read"}, pmem_read, 1'b0);
        chk({tag, "_pmem_write"}, pmem_write, 1'b0);
        chk({tag, "_pmem_address"}, pmem_address, 32'h0);
        chk({tag, "_pmem_wdata"}, pmem_wdata, '0);
        chk({tag, "_i_resp"}, i_resp, 1'b0);
        chk({tag, "_d_resp"}, d_resp, 1'b0);
        chk({tag, "_i_rdata"}, i_rdata, '0);
        chk({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    task automatic clear_logs();
        svc_log.delete();
        starve_log.delete();
        addr_log.delete();
        n_iresp = 0;
        n_dresp = 0;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    initial begin
        bit got;
        bit saw_read;
        int wr_cycles;

        step();
        step();
        chk_all_zero("reset");
        chk_int("reset_starve", int'(dut.starve_cnt), 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // icache only, memory latency 5
        clear_logs();
        mem_lat = 5;
        i_read  = 1'b1;
        i_addr  = 32'h0000_0064;
        step();
        chk("i_only_pmem_read", pmem_read, 1'b1);
        chk("i_only_address", pmem_address, 32'h0000_0060);
        got = 1'b0;
        for (int k = 2; k < 20 && !got; k++) begin
            step();
            if (i_resp) begin
                got = 1'b1;
                chk_int("i_only_resp_cycle", k, 7);
                chk("i_only_rdata", i_rdata, last_rdata);
            end
        end
        if (!got) timeout("i_only_resp");
        step();
        chk("i_only_resp_one_cycle", i_resp, 1'b0);
        chk_int("i_only_no_dresp", n_dresp, 0);

        // minimum latency: memory answers in the first serve cycle
        mem_lat = 0;
        i_read  = 1'b1;
        i_addr  = 32'h0000_0100;
        step();
        step();
        chk("min_lat_resp", i_resp, 1'b1);
        step();
        chk("min_lat_resp_done", i_resp, 1'b0);
        repeat (2) step();

        // simultaneous: D first, then I
        clear_logs();
        mem_lat = 2;
        i_read  = 1'b1;
        i_addr  = 32'h0000_0200;
        d_read  = 1'b1;
        d_addr  = 32'h2000_0040;
        for (int k = 0; k < 40 && (i_read || d_read); k++) step();
        if (i_read || d_read) timeout("simul_done");
        chk_int("simul_grants", svc_log.size(), 2);
        if (svc_log.size() == 2) begin
            chk_int("simul_first_is_d", svc_log[0], 2);
            chk_int("simul_second_is_i", svc_log[1], 1);
            chk_int("simul_starve_after_d", starve_log[0], 1);
            chk_int("simul_starve_after_i", starve_log[1], 0);
        end
        repeat (2) step();

        // writeback
        clear_logs();
        mem_lat   = 3;
        d_write   = 1'b1;
        d_addr    = 32'h1000_0020;
        d_wdata   = {32{8'hA5}};
        saw_read  = 1'b0;
        wr_cycles = 0;
        got       = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            saw_read = saw_read | pmem_read;
            if (pmem_write) begin
                wr_cycles++;
                chk("wb_address", pmem_address, 32'h1000_0020);
                chk("wb_wdata", pmem_wdata, {32{8'hA5}});
            end
            if (d_resp) got = 1'b1;
        end
        if (!got) timeout("wb_resp");
        chk("wb_no_read", saw_read, 1'b0);
        chk_int("wb_write_cycles", wr_cycles, 4);
        chk_int("wb_dresp_count", n_dresp, 1);
        repeat (2) step();

        // starvation guard: I held, D re-requests every idle
        clear_logs();
        mem_lat = 1;
        i_read  = 1'b1;
        i_addr  = 32'h0000_0300;
        d_read  = 1'b1;
        d_addr  = 32'h2000_0000;
        for (int k = 0; k < 200 && svc_log.size() < 6; k++) begin
            step();
            if (!d_read && !d_resp) begin
                d_read = 1'b1;
                d_addr = d_addr + 32'd32;
            end
        end
        chk_int("starve_grants", svc_log.size(), 6);
        if (svc_log.size() >= 6) begin
            for (int g = 0; g < 6; g++) chk_int($sformatf("starve_grant%0d", g), svc_log[g], (g == 4) ? 1 : 2);
        end
        for (int k = 0; k < 40 && (i_read || d_read); k++) step();
        repeat (2) step();

        // reset in the second SERVE_D cycle
        clear_logs();
        mem_lat = 20;
        d_read  = 1'b1;
        d_addr  = 32'h2000_0100;
        step();
        step();
        chk("rst_mid_serving", pmem_read, 1'b1);
        rst    = 1'b1;
        d_read = 1'b0;
        step();
        chk_all_zero("rst_mid");
        rst = 1'b0;
        repeat (3) step();
        chk_int("rst_mid_no_dresp", n_dresp, 0);
        mem_lat = 2;
        i_read  = 1'b1;
        i_addr  = 32'h0000_0400;
        got     = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (i_resp) got = 1'b1;
        end
        chk("rst_then_i_served", got, 1'b1);
        repeat (2) step();

        // back-to-back dcache request
        clear_logs();
        mem_lat = 1;
        d_read  = 1'b1;
        d_addr  = 32'h2000_0200;
        got     = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (d_resp) got = 1'b1;
        end
        if (!got) timeout("b2b_first_resp");
        step();
        d_read = 1'b1;
        d_addr = 32'h2000_0400;
        step();
        chk("b2b_regrant", pmem_read, 1'b1);
        chk("b2b_address", pmem_address, 32'h2000_0400);
        for (int k = 0; k < 20 && d_read; k++) step();
        repeat (3) step();
        chk_int("b2b_dresp_count", n_dresp, 2);
        chk_int("b2b_grants", svc_log.size(), 2);

        // randomized soak
        clear_logs();
        mem_lat  = -1;
        spurious = 1'b1;
        rand_on  = 1'b1;
        repeat (3000) step();
        rand_on  = 1'b0;
        spurious = 1'b0;
        rst      = 1'b0;
        i_read   = 1'b0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
